// File: rtl/accel_pkg.sv
// Shared constants, state encoding and width helper for the MNIST accelerator sequencer.
// The optional argmax stage is built when ACCEL_ARGMAX_EN is defined.
package accel_pkg;

  localparam int unsigned N_IN    = 785;   // 784 pixels + bias word
  localparam int unsigned N_HID   = 32;
  localparam int unsigned N_OUT   = 10;
  localparam int unsigned DW      = 32;
  localparam int unsigned TIMEOUT = 4096;

  typedef enum logic [2:0] {
    StIdle,
    StL1,
    StL2,
    StArgmax,
    StDone,
    StErr
  } state_e;

  // Bits needed to hold values 0..max_val inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  localparam int unsigned PHASE_W = cnt_width(TIMEOUT);
  localparam int unsigned IDX_W   = cnt_width(N_OUT);

endpackage

// File: rtl/accel_sequencer_if.sv
// Host/datapath-facing signal bundle of the run sequencer.
// master: the side driving requests and stop flags; slave: the sequencer itself.
interface accel_sequencer_if;

  logic                                             start_req;
  logic                                             stop1;
  logic                                             stop2;
  logic [accel_pkg::N_OUT*accel_pkg::DW-1:0]        result_bus;
  logic                                             busy;
  logic                                             done;
  logic                                             error;
  logic                                             start1;
  logic                                             start2;
  logic [31:0]                                      counter1;
  logic [31:0]                                      counter2;
  logic [3:0]                                       class_idx;
  logic [accel_pkg::DW-1:0]                         class_score;

  modport master (
    output start_req, stop1, stop2, result_bus,
    input  busy, done, error, start1, start2, counter1, counter2, class_idx, class_score
  );

  modport slave (
    input  start_req, stop1, stop2, result_bus,
    output busy, done, error, start1, start2, counter1, counter2, class_idx, class_score
  );

endinterface

// File: rtl/argmax_seq.sv
// Serial signed argmax over the snapshot of class scores, one score per cycle.
// start loads score 0; the remaining scores follow on consecutive cycles; valid rises once all
// N_OUT scores have been seen. Ties keep the lower index (strictly-greater replaces).
module argmax_seq
  import accel_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [N_OUT*DW-1:0]  scores,
  output logic [IDX_W-1:0]     idx,
  output logic signed [DW-1:0] best,
  output logic                 valid
);

  logic [IDX_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic signed [DW-1:0] best_q, best_d;
  logic signed [DW-1:0] score_arr [N_OUT];

  // Unpack the flat score bus into an indexable array.
  always_comb begin
    for (int k = 0; k < int'(N_OUT); k++) begin
      score_arr[k] = scores[k*DW +: DW];
    end
  end

  // Compare the current score against the running best.
  always_comb begin
    cnt_d  = cnt_q;
    idx_d  = idx_q;
    best_d = best_q;
    if (start) begin
      cnt_d  = IDX_W'(1);
      idx_d  = '0;
      best_d = score_arr[0];
    end else if (cnt_q != '0 && cnt_q < IDX_W'(N_OUT)) begin
      if (score_arr[cnt_q] > best_q) begin
        idx_d  = cnt_q;
        best_d = score_arr[cnt_q];
      end
      cnt_d = cnt_q + IDX_W'(1);
    end
  end

  // Running-max state.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      best_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      best_q <= best_d;
    end
  end

  assign idx   = idx_q;
  assign best  = best_q;
  assign valid = (cnt_q == IDX_W'(N_OUT));

endmodule

// File: rtl/accel_sequencer.sv
// Run sequencer for the MNIST accelerator: layer-1 feed, layer-2 feed, optional argmax, done.
// Define ACCEL_ARGMAX_EN to build the ARGMAX phase and argmax_seq; otherwise the run goes
// straight from L2 to DONE and reports class 0 with snapshot score 0.
module accel_sequencer
  import accel_pkg::*;
(
  input logic              clk,
  input logic              reset,
  accel_sequencer_if.slave bus
);

`ifdef ACCEL_ARGMAX_EN
  localparam state_e      StAfterL2 = StArgmax;
  localparam int unsigned SNAP_W    = N_OUT * DW;
`else
  localparam state_e      StAfterL2 = StDone;
  localparam int unsigned SNAP_W    = DW;  // only score 0 is ever reported
`endif

  state_e             state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [31:0]        cnt1_q, cnt1_d;
  logic [31:0]        cnt2_q, cnt2_d;
  logic [SNAP_W-1:0]  snap_q, snap_d;
  logic [IDX_W-1:0]   class_idx_q, class_idx_d;
  logic [DW-1:0]      class_score_q, class_score_d;

  logic               accept1, accept2, timed_out, launch;
  logic [IDX_W-1:0]   res_idx;
  logic [DW-1:0]      res_score;

  // Stop flags only count once the feed counters have covered the whole vector.
  assign accept1   = (state_q == StL1) && bus.stop1 && (cnt1_q >= 32'(N_IN));
  assign accept2   = (state_q == StL2) && bus.stop2 && (cnt2_q >= 32'(N_HID));
  assign timed_out = (phase_q == PHASE_W'(TIMEOUT - 1));
  assign launch    = ((state_q == StIdle) || (state_q == StErr)) && bus.start_req;

`ifdef ACCEL_ARGMAX_EN
  logic                 am_start, am_valid;
  logic [IDX_W-1:0]     am_idx;
  logic signed [DW-1:0] am_best;

  assign am_start = (state_q == StArgmax) && (phase_q == '0);

  argmax_seq u_argmax (
    .clk    (clk),
    .reset  (reset),
    .start  (am_start),
    .scores (snap_q),
    .idx    (am_idx),
    .best   (am_best),
    .valid  (am_valid)
  );

  assign res_idx   = am_valid ? am_idx : '0;
  assign res_score = am_valid ? am_best : snap_q[DW-1:0];
`else
  assign res_idx   = '0;
  assign res_score = snap_q[DW-1:0];
`endif

  // State and datapath registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      phase_q       <= '0;
      cnt1_q        <= '0;
      cnt2_q        <= '0;
      snap_q        <= '0;
      class_idx_q   <= '0;
      class_score_q <= '0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      cnt1_q        <= cnt1_d;
      cnt2_q        <= cnt2_d;
      snap_q        <= snap_d;
      class_idx_q   <= class_idx_d;
      class_score_q <= class_score_d;
    end
  end

  // Next-state: stop acceptance takes precedence over timeout in the same cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StErr: begin
        if (bus.start_req) state_d = StL1;
      end
      StL1: begin
        if (accept1)        state_d = StL2;
        else if (timed_out) state_d = StErr;
      end
      StL2: begin
        if (accept2)        state_d = StAfterL2;
        else if (timed_out) state_d = StErr;
      end
      StArgmax: begin
        if (phase_q == PHASE_W'(N_OUT - 1)) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Phase timer, feed counters, score snapshot and reported class.
  always_comb begin
    if (state_d != state_q)  phase_d = '0;
    else if (phase_q == '1)  phase_d = phase_q;
    else                     phase_d = phase_q + PHASE_W'(1);

    cnt1_d        = cnt1_q;
    cnt2_d        = cnt2_q;
    snap_d        = snap_q;
    class_idx_d   = class_idx_q;
    class_score_d = class_score_q;

    if (launch)                                   cnt1_d = '0;
    else if (state_q == StL1 && cnt1_q != '1)     cnt1_d = cnt1_q + 32'd1;

    if (accept1)                                  cnt2_d = '0;
    else if (state_q == StL2 && cnt2_q < 32'(N_HID)) cnt2_d = cnt2_q + 32'd1;

    if (accept2) snap_d = bus.result_bus[SNAP_W-1:0];

    if (state_q == StDone) begin
      class_idx_d   = res_idx;
      class_score_d = res_score;
    end
  end

  // Moore outputs; the class result is shown live during DONE and held afterwards.
  always_comb begin
    bus.busy        = state_q inside {StL1, StL2, StArgmax, StDone};
    bus.done        = (state_q == StDone);
    bus.error       = (state_q == StErr);
    bus.start1      = (state_q == StL1) && (phase_q == '0);
    bus.start2      = (state_q == StL2) && (phase_q == '0);
    bus.counter1    = cnt1_q;
    bus.counter2    = cnt2_q;
    bus.class_idx   = (state_q == StDone) ? res_idx : class_idx_q;
    bus.class_score = (state_q == StDone) ? res_score : class_score_q;
  end

endmodule

// File: tb/tb_accel_sequencer.sv
// Self-checking bench for accel_sequencer: timeline model derived from the run rules.
module tb_accel_sequencer;

  localparam int NIN  = 785;
  localparam int NHID = 32;
  localparam int NOUT = 10;
  localparam int TMO  = 4096;
  localparam int BIG  = 1 << 30;
`ifdef ACCEL_ARGMAX_EN
  localparam int AM_CYC = NOUT;
  localparam bit AM_EN  = 1'b1;
`else
  localparam int AM_CYC = 0;
  localparam bit AM_EN  = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic signed [31:0] sc_m [NOUT];
  logic [3:0]         prev_idx = '0;
  logic signed [31:0] prev_sc  = '0;

  accel_sequencer_if bus ();

  accel_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // One full run from IDLE/ERR; s1_at/s2_at < 0 means the stop flag never rises,
  // rst_j >= 0 asserts reset at that L2 cycle, stray pulses start_req in L1 and in DONE.
  task automatic do_run(input int s1_at, input int s2_at, input int rst_j, input bit stray);
    int a1, a2, t_l2, t_acc2, t_done, t_err, t_end, e2;
    bit has_l2, err;
    logic [3:0] exp_idx, want_idx;
    logic signed [31:0] exp_sc, want_sc;
    logic [4:0] obs_f, exp_f;
    exp_idx = '0;
    exp_sc  = sc_m[0];
    if (AM_EN) begin
      for (int k = 1; k < NOUT; k++) begin
        if (sc_m[k] > exp_sc) begin
          exp_idx = 4'(k);
          exp_sc  = sc_m[k];
        end
      end
    end
    for (int k = 0; k < NOUT; k++) bus.result_bus[k*32 +: 32] = sc_m[k];
    a1 = (s1_at < 0) ? BIG : ((s1_at > NIN) ? s1_at : NIN);
    err = 0; has_l2 = 0; t_l2 = BIG; t_acc2 = BIG; t_done = BIG; t_err = BIG;
    if (a1 > TMO - 1) begin
      err = 1; t_err = TMO;
    end else begin
      has_l2 = 1; t_l2 = a1 + 1;
      a2 = (s2_at < 0) ? BIG : ((s2_at > NHID) ? s2_at : NHID);
      if (a2 > TMO - 1) begin
        err = 1; t_err = t_l2 + TMO;
      end else begin
        t_acc2 = t_l2 + a2; t_done = t_acc2 + 1 + AM_CYC;
      end
    end
    t_end = err ? t_err + 3 : t_done + 2;
    if (rst_j >= 0) t_end = t_l2 + rst_j + 1;

    bus.start_req = 1'b1;
    @(negedge clk);
    bus.start_req = 1'b0;
    for (int t = 0; t <= t_end; t++) begin
      if (rst_j >= 0 && t == t_end) begin
        checks++;
        if ({bus.busy, bus.done, bus.error, bus.start1, bus.start2, bus.counter1,
             bus.counter2, bus.class_idx, bus.class_score} !== '0)
          begin
          errors++;
          $display("FAIL reset_clear t=%0d busy=%b done=%b err=%b c1=%0d c2=%0d idx=%0d sc=%0d, want all 0",
                   t, bus.busy, bus.done, bus.error, bus.counter1, bus.counter2,
                   bus.class_idx, bus.class_score);
        end
        reset = 1'b0;
        prev_idx = '0;
        prev_sc = '0;
      end else begin
        exp_f[4] = (t < (err ? t_err : t_done + 1));
        exp_f[3] = (t == t_done);
        exp_f[2] = err && (t >= t_err);
        exp_f[1] = (t == 0);
        exp_f[0] = has_l2 && (t == t_l2);
        obs_f = {bus.busy, bus.done, bus.error, bus.start1, bus.start2};
        checks++;
        if (obs_f !== exp_f) begin
          errors++;
          $display("FAIL flags t=%0d busy/done/err/st1/st2 got %b want %b", t, obs_f, exp_f);
        end
        if (t < t_l2 && t < t_err) begin
          checks++;
          if (bus.counter1 !== 32'(t)) begin
            errors++;
            $display("FAIL counter1 t=%0d got %0d want %0d", t, bus.counter1, t);
          end
        end
        if (has_l2 && t >= t_l2 && (t <= t_acc2 || (err && t < t_err))) begin
          e2 = (t - t_l2 < NHID) ? t - t_l2 : NHID;
          checks++;
          if (bus.counter2 !== 32'(e2)) begin
            errors++;
            $display("FAIL counter2 t=%0d got %0d want %0d", t, bus.counter2, e2);
          end
        end
        if (!err && t > t_done) begin
          checks++;
          if (bus.counter2 !== 32'(NHID)) begin
            errors++;
            $display("FAIL counter2_hold t=%0d got %0d want %0d", t, bus.counter2, NHID);
          end
        end
        want_idx = (t >= t_done) ? exp_idx : prev_idx;
        want_sc  = (t >= t_done) ? exp_sc : prev_sc;
        checks++;
        if (bus.class_idx !== want_idx || bus.class_score !== want_sc) begin
          errors++;
          $display("FAIL class t=%0d got idx=%0d score=%0d want idx=%0d score=%0d", t,
                   bus.class_idx, $signed(bus.class_score), want_idx, want_sc);
        end
      end
      bus.stop1 = (s1_at >= 0) && (t >= s1_at) && (t < t_l2);
      bus.stop2 = has_l2 && (s2_at >= 0) && (t >= t_l2 + s2_at) && (t <= t_acc2);
      bus.start_req = stray && (t == 100 || t == t_done);
      if (rst_j >= 0 && t == t_l2 + rst_j) reset = 1'b1;
      if (t < t_end) @(negedge clk);
    end
    bus.stop1 = 1'b0;
    bus.stop2 = 1'b0;
    bus.start_req = 1'b0;
    if (!err && rst_j < 0) begin
      prev_idx = exp_idx;
      prev_sc  = exp_sc;
    end
  endtask

  task automatic test_reset();
    bus.start_req = 1'b0; bus.stop1 = 1'b0; bus.stop2 = 1'b0; bus.result_bus = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.error, bus.start1, bus.start2, bus.counter1, bus.counter2,
         bus.class_idx, bus.class_score} !== '0) begin
      errors++;
      $display("FAIL reset_state busy=%b done=%b err=%b c1=%0d c2=%0d, want all 0",
               bus.busy, bus.done, bus.error, bus.counter1, bus.counter2);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.start1 !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset busy=%b start1=%b want 0 0", bus.busy, bus.start1);
    end
  endtask

  task automatic test_nominal();
    for (int k = 0; k < NOUT; k++) sc_m[k] = '0;
    sc_m[0] = 32'sd3; sc_m[1] = -32'sd1; sc_m[2] = 32'sd9; sc_m[3] = 32'sd9;
    do_run(817, 40, -1, 0);
    checks++;
    if (bus.class_idx !== (AM_EN ? 4'd2 : 4'd0)) begin
      errors++;
      $display("FAIL nominal_idx got %0d want %0d", bus.class_idx, AM_EN ? 2 : 0);
    end
  endtask

  task automatic test_early_stop();
    for (int k = 0; k < NOUT; k++) sc_m[k] = 32'(k * 7 - 20);
    do_run(0, 0, -1, 0);
  endtask

  task automatic test_timeout();
    do_run(785, -1, -1, 0);
    repeat (5) @(negedge clk);
    checks++;
    if (bus.error !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL error_sticky got err=%b busy=%b want 1 0", bus.error, bus.busy);
    end
    for (int k = 0; k < NOUT; k++) sc_m[k] = 32'(100 - k);
    do_run(800, 32, -1, 0);
  endtask

  task automatic test_l1_timeout();
    do_run(-1, -1, -1, 0);
    do_run(790, 35, -1, 0);
  endtask

  task automatic test_reset_mid_run();
    for (int k = 0; k < NOUT; k++) sc_m[k] = 32'(k);
    do_run(820, 40, 12, 0);
    do_run(786, 33, -1, 0);
  endtask

  task automatic test_ignored_start();
    for (int k = 0; k < NOUT; k++) sc_m[k] = 32'((k == 6) ? 50 : k);
    do_run(790, 33, -1, 1);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.busy !== 1'b0 || bus.start1 !== 1'b0 || bus.done !== 1'b0) begin
        errors++;
        $display("FAIL no_restart i=%0d busy=%b start1=%b done=%b want 0 0 0", i,
                 bus.busy, bus.start1, bus.done);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_negative_scores();
    for (int k = 0; k < NOUT; k++) sc_m[k] = -32'(5 + k);
    do_run(800, 36, -1, 0);
    checks++;
    if (bus.class_idx !== 4'd0 || bus.class_score !== -32'sd5) begin
      errors++;
      $display("FAIL negative_class got idx=%0d score=%0d want idx=0 score=-5",
               bus.class_idx, $signed(bus.class_score));
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < NOUT; k++) begin
        if (r % 2 == 0) sc_m[k] = 32'(int'($urandom_range(0, 7)) - 4);
        else            sc_m[k] = $urandom;
      end
      do_run(int'($urandom_range(700, 900)), int'($urandom_range(0, 60)), -1, r == 3);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_early_stop();
    test_timeout();
    test_l1_timeout();
    test_reset_mid_run();
    test_ignored_start();
    test_negative_scores();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
